// File: rtl/s2p_frame_ctrl.sv
// ---------------------------------------------------------------------------
// s2p_frame_ctrl
// Serial-to-parallel framer. Hunts for an N-bit sync pattern in an LSB-first
// bit stream, then captures WORDS words of N bits each. The words go into a
// DEPTH-entry output buffer drained with a valid/ready handshake.
//
// Optional build macro:
//   S2P_PARITY_EN - each data word is followed by one even-parity bit. A
//                   mismatch is flagged on word_perr. The word is pushed on
//                   the parity-bit edge.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   data_in      serial data bit, sampled every edge
//   enable       1 = run the sequencer, 0 = return to IDLE
//   ovf_clear    pulse that clears the sticky overflow flag
//   word_ready   consumer accepts the head word
//   word_valid   buffer not empty
//   word_data    head word (bit k = k-th received data bit)
//   word_first   head word is word 0 of its frame
//   word_last    head word is word WORDS-1 of its frame
//   word_perr    head word failed its parity check
//   in_frame     sequencer is capturing a frame
//   overflow     sticky: a completed word was dropped
//   frame_count  completed frames, wraps at 255
// ---------------------------------------------------------------------------
module s2p_frame_ctrl #(
    parameter int unsigned  N     = 8,
    parameter logic [N-1:0] SYNC  = N'(8'hA5),
    parameter int unsigned  WORDS = 4,
    parameter int unsigned  DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         data_in,
    input  logic         enable,
    input  logic         ovf_clear,
    input  logic         word_ready,
    output logic         word_valid,
    output logic [N-1:0] word_data,
    output logic         word_first,
    output logic         word_last,
    output logic         word_perr,
    output logic         in_frame,
    output logic         overflow,
    output logic [7:0]   frame_count
);

`ifdef S2P_PARITY_EN
    localparam int unsigned LAST_CNT = N;
`else
    localparam int unsigned LAST_CNT = N - 1;
`endif
    localparam int unsigned BW = (LAST_CNT > 0) ? $clog2(LAST_CNT + 1) : 1;
    localparam int unsigned FW = $clog2(N + 1);
    localparam int unsigned WW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef struct packed {
        logic [N-1:0] data;
        logic         first;
        logic         last;
        logic         perr;
    } entry_t;

    state_t         state;
    state_t         state_next;

    logic [N-1:0]   window;
    logic [N-1:0]   window_shift;
    logic [FW-1:0]  fill;
    logic [BW-1:0]  bit_cnt;
    logic [WW-1:0]  word_cnt;
    logic [N-1:0]   word_reg;
    logic [N-1:0]   word_cur;
    logic           perr_in;

    logic           sync_hit;
    logic           word_done;
    logic           last_word;
    logic           hunt_en;
    logic           capture_en;
    logic           enter_hunt;

    entry_t         mem [DEPTH];
    entry_t         head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           pop;
    logic           push_ok;
    logic           drop;

    // Status terms shared by the FSM and the datapath
    assign window_shift = {data_in, window[N-1:1]};
    assign sync_hit     = (state == HUNT) && enable && (fill >= FW'(N - 1))
                          && (window_shift == SYNC);
    assign word_done    = (state == CAPTURE) && enable && (bit_cnt == BW'(LAST_CNT));
    assign last_word    = (word_cnt == WW'(WORDS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; enable low overrides everything
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = HUNT;
                HUNT:    if (sync_hit) state_next = CAPTURE;
                CAPTURE: if (word_done && last_word) state_next = HUNT;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs and datapath strobes
    always_comb begin
        hunt_en    = 1'b0;
        capture_en = 1'b0;
        enter_hunt = 1'b0;
        in_frame   = (state == CAPTURE);
        if (enable) begin
            case (state)
                IDLE:    enter_hunt = 1'b1;
                HUNT:    hunt_en = 1'b1;
                CAPTURE: begin
                    capture_en = 1'b1;
                    enter_hunt = word_done && last_word;
                end
                default: ;
            endcase
        end
    end

    // Current word with this edge's sample merged in (parity edge leaves it unchanged)
    always_comb begin
        word_cur = word_reg;
        for (int unsigned i = 0; i < N; i++) begin
            if (bit_cnt == BW'(i)) word_cur[i] = data_in;
        end
    end

`ifdef S2P_PARITY_EN
    assign perr_in = (^word_cur) ^ data_in;
`else
    assign perr_in = 1'b0;
`endif

    // Sync window, bit/word counters and frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            window      <= '0;
            fill        <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            word_reg    <= '0;
            frame_count <= '0;
        end else begin
            if (enter_hunt) begin
                window <= '0;
                fill   <= '0;
            end else if (hunt_en) begin
                window <= window_shift;
                if (fill != FW'(N)) fill <= fill + FW'(1);
            end

            if (sync_hit) begin
                bit_cnt  <= '0;
                word_cnt <= '0;
                word_reg <= '0;
            end else if (capture_en) begin
                word_reg <= word_cur;
                if (word_done) begin
                    bit_cnt <= '0;
                    // Dropped words still advance the word counter
                    if (last_word) begin
                        word_cnt    <= '0;
                        frame_count <= frame_count + 8'd1;
                    end else begin
                        word_cnt <= word_cnt + WW'(1);
                    end
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

    // Output buffer: a full buffer accepts a push only alongside a pop
    assign full    = (count == CW'(DEPTH));
    assign pop     = word_valid && word_ready;
    assign push_ok = word_done && (!full || pop);
    assign drop    = word_done && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{data:  word_cur,
                             first: (word_cnt == '0),
                             last:  last_word,
                             perr:  perr_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (pop)     rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    // Head-of-buffer outputs, forced to zero while empty
    assign head       = mem[rd_ptr];
    assign word_valid = (count != '0);
    assign word_data  = word_valid ? head.data  : '0;
    assign word_first = word_valid ? head.first : 1'b0;
    assign word_last  = word_valid ? head.last  : 1'b0;
    assign word_perr  = word_valid ? head.perr  : 1'b0;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_s2p_frame_ctrl
// Self-checking bench for s2p_frame_ctrl (N=8, SYNC=8'hA5, WORDS=4, DEPTH=4).
// Expected words are queued as stimulus is driven; a negedge monitor pops
// and compares on every handshake and checks zeroed outputs when empty.
// ---------------------------------------------------------------------------
module tb_s2p_frame_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_in;
    logic       enable;
    logic       ovf_clear;
    logic       word_ready;
    logic       word_valid;
    logic [7:0] word_data;
    logic       word_first;
    logic       word_last;
    logic       word_perr;
    logic       in_frame;
    logic       overflow;
    logic [7:0] frame_count;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    s2p_frame_ctrl #(.N(8), .SYNC(8'hA5), .WORDS(4), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .enable      (enable),
        .ovf_clear   (ovf_clear),
        .word_ready  (word_ready),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_first  (word_first),
        .word_last   (word_last),
        .word_perr   (word_perr),
        .in_frame    (in_frame),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (!reset) begin
            got = {word_data, word_first, word_last, word_perr};
            if (word_valid && word_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL word_unexpected: got data=%h first=%b last=%b perr=%b, required no word",
                             word_data, word_first, word_last, word_perr);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want)
                        $display("FAIL word_out: got data=%h first=%b last=%b perr=%b, required data=%h first=%b last=%b perr=%b",
                                 got.data, got.first, got.last, got.perr,
                                 want.data, want.first, want.last, want.perr);
                    else
                        passes++;
                end
            end else if (!word_valid) begin
                checks++;
                if (got !== '0)
                    $display("FAIL empty_zero: got %h, required 0", got);
                else
                    passes++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        data_in    = 1'b0;
        ovf_clear  = 1'b0;
        word_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic start_hunt();
        enable  = 1'b1;
        data_in = 1'b0;
        tick();
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        tick();
    endtask

    task automatic send_sync_bits(input int nbits);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < nbits; i++) send_bit(s[i]);
    endtask

    // One word (plus its correct parity bit when enabled); clr pulses ovf_clear on the push edge
    task automatic send_word(input logic [7:0] b, input logic clr);
        for (int i = 0; i < 8; i++) begin
            data_in = b[i];
`ifndef S2P_PARITY_EN
            ovf_clear = clr && (i == 7);
`endif
            tick();
        end
`ifdef S2P_PARITY_EN
        data_in   = ^b;
        ovf_clear = clr;
        tick();
`endif
        ovf_clear = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input logic expect_out);
        send_sync_bits(8);
        for (int w = 0; w < 4; w++) begin
            if (expect_out)
                exp_q.push_back('{data: base + 8'(w + 1), first: (w == 0), last: (w == 3), perr: 1'b0});
            send_word(base + 8'(w + 1), 1'b0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({word_valid, word_data, word_first, word_last, word_perr, in_frame, overflow, frame_count} !== '0)
            $display("FAIL reset_outputs: got valid=%b data=%h in_frame=%b ovf=%b fc=%0d, required all 0",
                     word_valid, word_data, in_frame, overflow, frame_count);
        else
            passes++;
    endtask

    task automatic test_frame();
        do_reset();
        word_ready = 1'b1;
        start_hunt();
        send_sync_bits(8);
        checks++;
        if (in_frame !== 1'b1) $display("FAIL frame_in_frame: got %b, required 1", in_frame);
        else passes++;
        exp_q.push_back('{data: 8'h01, first: 1'b1, last: 1'b0, perr: 1'b0});
        send_word(8'h01, 1'b0);
        checks++;
        if ({word_valid, word_data} !== {1'b1, 8'h01})
            $display("FAIL frame_latency: got valid=%b data=%h, required valid=1 data=01", word_valid, word_data);
        else passes++;
        for (int w = 1; w < 4; w++) begin
            exp_q.push_back('{data: 8'(w + 1), first: 1'b0, last: (w == 3), perr: 1'b0});
            send_word(8'(w + 1), 1'b0);
        end
        repeat (4) tick();
        checks++;
        if ({frame_count, in_frame} !== {8'd1, 1'b0})
            $display("FAIL frame_done: got fc=%0d in_frame=%b, required fc=1 in_frame=0", frame_count, in_frame);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL frame_drain: got %0d pending, required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_backpressure();
        do_reset();
        start_hunt();
        send_frame(8'h10, 1'b1);
        checks++;
        if ({overflow, word_valid} !== 2'b01)
            $display("FAIL bp_full_no_ovf: got ovf=%b valid=%b, required ovf=0 valid=1", overflow, word_valid);
        else passes++;
        send_sync_bits(8);
        send_word(8'h21, 1'b0);
        send_word(8'h22, 1'b1);
        checks++;
        if (overflow !== 1'b1) $display("FAIL bp_drop_wins: got %b, required 1", overflow);
        else passes++;
        send_word(8'h23, 1'b0);
        send_word(8'h24, 1'b0);
        checks++;
        if ({overflow, frame_count, word_data, word_first} !== {1'b1, 8'd2, 8'h11, 1'b1})
            $display("FAIL bp_state: got ovf=%b fc=%0d head=%h first=%b, required ovf=1 fc=2 head=11 first=1",
                     overflow, frame_count, word_data, word_first);
        else passes++;
        word_ready = 1'b1;
        repeat (8) tick();
        checks++;
        if ({word_valid, exp_q.size() == 0} !== 2'b01)
            $display("FAIL bp_drain: got valid=%b pending=%0d, required valid=0 pending=0", word_valid, exp_q.size());
        else passes++;
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) $display("FAIL bp_ovf_clear: got %b, required 0", overflow);
        else passes++;
    endtask

    task automatic test_false_sync();
        logic [7:0] fake;
        logic       early;
        do_reset();
        word_ready = 1'b1;
        start_hunt();
        fake  = 8'hA4;
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit(fake[i]);
            if (in_frame) early = 1'b1;
        end
        send_sync_bits(7);
        if (in_frame) early = 1'b1;
        checks++;
        if (early !== 1'b0) $display("FAIL false_sync_early: got capture before A5, required none");
        else passes++;
        send_bit(1'b1);
        checks++;
        if (in_frame !== 1'b1) $display("FAIL false_sync_lock: got %b, required 1", in_frame);
        else passes++;
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back('{data: 8'h5A + 8'(w), first: (w == 0), last: (w == 3), perr: 1'b0});
            send_word(8'h5A + 8'(w), 1'b0);
        end
        repeat (3) tick();
        checks++;
        if (frame_count !== 8'd1) $display("FAIL false_sync_fc: got %0d, required 1", frame_count);
        else passes++;
    endtask

    task automatic test_abort();
        do_reset();
        word_ready = 1'b1;
        start_hunt();
        send_sync_bits(8);
        exp_q.push_back('{data: 8'h01, first: 1'b1, last: 1'b0, perr: 1'b0});
        send_word(8'h01, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        enable = 1'b0;
        tick();
        checks++;
        if (in_frame !== 1'b0) $display("FAIL abort_idle: got in_frame=%b, required 0", in_frame);
        else passes++;
        // IDLE must not hunt even when the sync pattern goes by
        send_sync_bits(8);
        repeat (2) tick();
        checks++;
        if ({in_frame, word_valid, frame_count} !== {1'b0, 1'b0, 8'd0})
            $display("FAIL abort_quiet: got in_frame=%b valid=%b fc=%0d, required 0 0 0", in_frame, word_valid, frame_count);
        else passes++;
        start_hunt();
        send_sync_bits(7);
        checks++;
        if (in_frame !== 1'b0) $display("FAIL abort_rehunt: got %b, required 0", in_frame);
        else passes++;
        send_bit(1'b1);
        checks++;
        if (in_frame !== 1'b1) $display("FAIL abort_relock: got %b, required 1", in_frame);
        else passes++;
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back('{data: 8'hC0 + 8'(w), first: (w == 0), last: (w == 3), perr: 1'b0});
            send_word(8'hC0 + 8'(w), 1'b0);
        end
        repeat (3) tick();
        checks++;
        if (frame_count !== 8'd1) $display("FAIL abort_fc: got %0d, required 1", frame_count);
        else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        word_ready = 1'b1;
        start_hunt();
        send_frame(8'h40, 1'b1);
        repeat (3) tick();
        word_ready = 1'b0;
        send_sync_bits(8);
        send_word(8'h31, 1'b0);
        send_word(8'h32, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        checks++;
        if ({word_valid, word_data, frame_count, in_frame} !== {1'b1, 8'h31, 8'd1, 1'b1})
            $display("FAIL rmid_before: got valid=%b head=%h fc=%0d in_frame=%b, required 1 31 1 1",
                     word_valid, word_data, frame_count, in_frame);
        else passes++;
        reset = 1'b1;
        tick();
        checks++;
        if ({word_valid, frame_count, overflow, in_frame} !== {1'b0, 8'd0, 1'b0, 1'b0})
            $display("FAIL rmid_after: got valid=%b fc=%0d ovf=%b in_frame=%b, required 0 0 0 0",
                     word_valid, frame_count, overflow, in_frame);
        else passes++;
        reset      = 1'b0;
        word_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (word_valid !== 1'b0) $display("FAIL rmid_no_words: got %b, required 0", word_valid);
        else passes++;
    endtask

`ifdef S2P_PARITY_EN
    task automatic test_parity();
        do_reset();
        word_ready = 1'b1;
        start_hunt();
        send_sync_bits(8);
        for (int i = 0; i < 8; i++) send_bit(i < 2);
        checks++;
        if (word_valid !== 1'b0) $display("FAIL par_latency: got valid=%b, required 0", word_valid);
        else passes++;
        exp_q.push_back('{data: 8'h03, first: 1'b1, last: 1'b0, perr: 1'b1});
        send_bit(1'b1);
        checks++;
        if ({word_valid, word_perr} !== 2'b11)
            $display("FAIL par_bad: got valid=%b perr=%b, required 1 1", word_valid, word_perr);
        else passes++;
        exp_q.push_back('{data: 8'h03, first: 1'b0, last: 1'b0, perr: 1'b0});
        for (int i = 0; i < 8; i++) send_bit(i < 2);
        send_bit(1'b0);
        checks++;
        if ({word_valid, word_perr} !== 2'b10)
            $display("FAIL par_good: got valid=%b perr=%b, required 1 0", word_valid, word_perr);
        else passes++;
        exp_q.push_back('{data: 8'h07, first: 1'b0, last: 1'b0, perr: 1'b0});
        send_word(8'h07, 1'b0);
        exp_q.push_back('{data: 8'h08, first: 1'b0, last: 1'b1, perr: 1'b0});
        send_word(8'h08, 1'b0);
        repeat (3) tick();
        checks++;
        if (frame_count !== 8'd1) $display("FAIL par_fc: got %0d, required 1", frame_count);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_false_sync();
        test_abort();
        test_reset_mid();
`ifdef S2P_PARITY_EN
        test_parity();
`endif
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL final_pending: got %0d, required 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/s2p_frame_ctrl.md
S2P_FRAME_CTRL -- requirements
Module: s2p_frame_ctrl

Interface
REQ-001 Parameter N, default 8: word width in bits.
REQ-002 Parameter SYNC, default 8'hA5 (width N): frame sync pattern.
REQ-003 Parameter WORDS, default 4: data words per frame, at least 1.
REQ-004 Parameter DEPTH, default 4: output buffer entries, power of 2.
REQ-005 clk  input  1  the only clock; all logic SHALL use the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  1  serial bit, sampled every rising edge, LSB-first.
REQ-008 enable  input  1  1 = run the sequencer, 0 = return to IDLE.
REQ-009 ovf_clear  input  1  single-cycle pulse that clears overflow.
REQ-010 word_ready  input  1  consumer accepts the head word.
REQ-011 word_valid  output  1  buffer not empty.
REQ-012 word_data  output  N  head word; bit k = k-th received data bit.
REQ-013 word_first  output  1  head word is word 0 of its frame.
REQ-014 word_last  output  1  head word is word WORDS-1 of its frame.
REQ-015 word_perr  output  1  head word failed its parity check.
REQ-016 in_frame  output  1  FSM is in CAPTURE.
REQ-017 overflow  output  1  sticky flag: a word was dropped.
REQ-018 frame_count  output  8  count of completed frames, wraps 255->0.

Function
REQ-019 The FSM SHALL have three states, IDLE, HUNT and CAPTURE; enable=0 SHALL force IDLE on the next edge from any state.
REQ-020 IDLE->HUNT SHALL occur on the first edge with enable=1; entering HUNT SHALL clear the window and the fill counter.
REQ-021 HUNT SHALL shift data_in into the window MSB (right shift). A match SHALL require at least N bits shifted since entering HUNT and the updated window equal to SYNC; a match SHALL move to CAPTURE with bit counter = 0 and word counter = 0.
REQ-022 CAPTURE SHALL write the bit sampled at count k into word[k]; the sample at count N-1 completes the word.
REQ-023 A completed word SHALL be pushed with first=(word counter==0) and last=(word counter==WORDS-1); word_valid SHALL be 1 in the cycle after the edge that sampled the final bit if the buffer was empty.
REQ-024 After word WORDS-1, the FSM SHALL return to HUNT and frame_count SHALL increment, including when words in that frame were dropped.
REQ-025 The buffer SHALL pop on word_valid && word_ready. When the buffer is full, a push SHALL succeed only with a pop in the same cycle; otherwise the word SHALL be dropped and overflow set. Dropped words still advance the word counter.
REQ-026 ovf_clear SHALL clear overflow; a drop in the same cycle SHALL win, leaving overflow = 1.
REQ-027 enable falling mid-word SHALL discard the partial word. Words already buffered SHALL remain and SHALL still drain.
REQ-028 word_data, word_first, word_last and word_perr SHALL be 0 whenever word_valid=0.

Reset
REQ-029 reset SHALL force IDLE, empty the buffer, and clear the counters, window and overflow. All outputs SHALL be 0 from the edge sampling reset=1; reset mid-frame SHALL discard all words.

Configuration
REQ-030 With S2P_PARITY_EN defined, each data word SHALL be followed by one even-parity bit. The parity bit is the expected XOR of the data bits. A mismatch SHALL set word_perr on that word, and the word SHALL be pushed on the parity-bit edge, which adds one cycle of latency.
REQ-031 Without S2P_PARITY_EN, no parity bit SHALL be consumed and word_perr SHALL be tied to 0.

Verification (N=8, SYNC=8'hA5, WORDS=4, DEPTH=4)
REQ-032 Frame: enable=1, ready=1, send bits 1,0,1,0,0,1,0,1 then words 0x01, 0x02, 0x03, 0x04 LSB-first -> 4 words out in order, first on 0x01, last on 0x04, frame_count=1, in_frame=0 afterwards.
REQ-033 Backpressure: ready=0, send 2 frames of 0x11..0x14 and 0x21..0x24 -> buffer holds 0x11..0x14, overflow=1, frame_count=2; then ready=1 -> exactly 4 words drain; ovf_clear pulse -> overflow=0.
REQ-034 False sync: send 0xA4 then 0xA5 -> HUNT continues through the 0xA4 bits, CAPTURE starts only after the 0xA5 bits, and no word is emitted early.
REQ-035 Abort: enable=0 after 3 bits of word 1 -> word 0 still delivered, no further words, FSM in IDLE; re-enable -> full HUNT required.
REQ-036 Reset mid-CAPTURE with 2 buffered words -> word_valid=0, frame_count=0 and overflow=0 on the next cycle.
REQ-037 Parity (S2P_PARITY_EN defined): word 0x03 followed by parity bit 1 -> word_perr=1; word 0x03 followed by parity bit 0 -> word_perr=0.
